packet_loader_mc: RTL and testbench
===================================

Name: packet_loader_mc

Overview:
- Pipelined, parametrised successor to the single-outstanding packet loader.
- Accepts packet requests and issues memory reads at OPADDR + request address, with up to DEPTH reads in flight.
- Pairs in-order memory responses with the request tag and routes each packet to one of N_CH consumers (queue, function expander, memory accessor, …) by opcode.
- Unroutable packets are dropped and counted, never stall the pipe.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory word width.
- AFLD_W, 16, width of the address field in the request, PR bits [AFLD_W-1:0].
- TAG_W, 16, width of the tag field in the request, PR bits [AFLD_W+TAG_W-1:AFLD_W].
- DEPTH, 4, maximum requests in flight (power of two, ≥2).
- N_CH, 3, number of output channels.
- OPC_LSB, 28, LSB of the opcode within the memory word.
- OPC_W, 4, opcode width.
- CH_OPCODES, {4'd2,4'd1,4'd0}, concatenated opcodes; channel i matches CH_OPCODES[i*OPC_W +: OPC_W].

Ports:
- CLK in 1: clock.
- RST in 1: reset, synchronous, active-high.
- OPADDR in ADDR_W: base address added to every request address.
- RECEIVE_PR_VALID in 1: request valid.
- RECEIVE_PR_DATA in AFLD_W+TAG_W: {tag, addr}.
- RECEIVE_PR_READY out 1: request accepted when VALID&&READY.
- MEM_SEND_ADDR_VALID out 1: read address valid.
- MEM_SEND_ADDR out ADDR_W: read address.
- MEM_SEND_READY in 1: memory accepts address.
- MEM_SEND_DATA_VALID out 1: constant 0.
- MEM_SEND_DATA out DATA_W: constant 0.
- MEM_RECEIVE_VALID in 1: read data valid, in request order.
- MEM_RECEIVE_DATA in DATA_W: read data.
- MEM_RECEIVE_READY out 1: constant 1.
- SEND_PC_VALID out N_CH: per-channel packet valid, at most one bit set.
- SEND_PC_DATA out TAG_W+DATA_W: packet {tag, word}, shared by all channels.
- SEND_PC_READY in N_CH: per-channel ready.
- DROP_COUNT out 16: saturating count of unroutable packets.
- ERR out 1: sticky, set on a memory response with no pending tag.
- BUSY out 1: inflight != 0.

Behaviour:
- Reset values: RECEIVE_PR_READY=0, MEM_SEND_ADDR_VALID=0, MEM_SEND_ADDR=0, SEND_PC_VALID=0, DROP_COUNT=0, ERR=0, BUSY=0. Both FIFOs are emptied and inflight is 0.
- Reset mid-operation abandons all in-flight requests. Responses arriving after reset set ERR.
- inflight counter (0..DEPTH):
  - increments on request accept;
  - decrements on packet output handshake or drop;
  - is unchanged when both occur in the same cycle.
- RECEIVE_PR_READY is a registered output, equal to 1 when all of these hold at the next edge:
  - not in reset;
  - inflight after update < DEPTH;
  - the address register will be free.
- Address register is free when MEM_SEND_ADDR_VALID=0, or MEM_SEND_READY=1 in this cycle.
- On accept:
  - MEM_SEND_ADDR <= (OPADDR + zero_extend(addr)) mod 2^ADDR_W, using OPADDR as sampled on the accept cycle;
  - MEM_SEND_ADDR_VALID <= 1 the next cycle;
  - tag pushed into the tag FIFO (depth DEPTH).
- While MEM_SEND_ADDR_VALID=1 and MEM_SEND_READY=0, MEM_SEND_ADDR is held stable. The valid clears after the handshake unless a new accept reloads it in the same cycle (back-to-back issue, one address per cycle).
- On MEM_RECEIVE_VALID:
  - pop the tag FIFO head;
  - push {tag, word} into the result FIFO (depth DEPTH).
  - Neither FIFO overflows, because inflight ≤ DEPTH.
- MEM_RECEIVE_VALID with an empty tag FIFO: data is discarded, ERR <= 1, and no other state changes.
- Output stage (registered head of the result FIFO):
  - opc = word[OPC_LSB +: OPC_W];
  - the selected channel is the lowest i with a CH_OPCODES match;
  - SEND_PC_VALID[i]=1 and SEND_PC_DATA are held stable until SEND_PC_READY[i]=1;
  - then pop, and the next entry is presented the following cycle.
- No channel matches: the entry is popped one cycle after it reaches the head and no SEND_PC_VALID bit rises. DROP_COUNT increments, saturating at 16'hFFFF.
- Latency:
  - request accepted at edge n gives address valid at cycle n+1;
  - response at edge k gives SEND_PC_VALID at cycle k+1, when the result FIFO was empty.
- Throughput: one request, one address and one packet per cycle in steady state with all readies high.
- Full: with inflight==DEPTH, RECEIVE_PR_READY=0 until a packet leaves. It then rises the cycle after the leaving handshake.

Test Plan:
- Single request: OPADDR=0x1000, PR={tag 0x00AB, addr 0x0010}, memory returns 0x10000005 after 3 cycles -> MEM_SEND_ADDR=0x1010; SEND_PC_VALID=3'b010; data 0x00AB_10000005; BUSY returns 0.
- Pipelining: 4 requests back-to-back, memory ready always, responses delayed 5 cycles -> 4 consecutive address handshakes. 5th request is stalled: RECEIVE_PR_READY=0 until the first packet handshake. Packets leave in request order with tags matching.
- Backpressure: channel 0 ready low for 10 cycles with opcode 0 at the head -> SEND_PC_VALID=3'b001 and data stable for all 10 cycles; a following opcode-1 packet is not reordered past it.
- Drop: word 0xF0000000 (opcode 15) -> no valid bit rises, DROP_COUNT=1, inflight decremented, the next packet is delivered normally.
- Errors/reset: MEM_RECEIVE_VALID with no pending request -> ERR=1, DROP_COUNT unchanged. RST asserted with 3 in flight -> all outputs at reset values the next cycle, and RECEIVE_PR_READY=1 one cycle after RST deasserts.
- Wrap: OPADDR=0xFFFFFFF0, addr 0x0020 -> MEM_SEND_ADDR=0x00000010.

Source files
------------

// File: rtl/packet_loader_mc.sv
// ---------------------------------------------------------------------------
// packet_loader_mc
// Pipelined packet loader. Each request {tag, addr} becomes a memory read at
// OPADDR + addr, with up to DEPTH requests in flight. In-order read data is
// paired with its tag and routed by opcode to one of N_CH consumers. Packets
// whose opcode matches no channel are dropped and counted, and never stall
// the pipe.
//
// Ports
//   CLK, RST             clock; synchronous active-high reset
//   OPADDR               base address added to every request address
//   RECEIVE_PR_*         request channel {tag, addr}, registered READY
//   MEM_SEND_ADDR_*      read address channel (write data tied off)
//   MEM_SEND_DATA_*      unused write channel, tied to 0
//   MEM_RECEIVE_*        read data, returned in request order, READY tied 1
//   SEND_PC_*            per-channel valid/ready, shared {tag, word} data
//   DROP_COUNT           saturating count of unroutable packets
//   ERR                  sticky: read data arrived with no pending tag
//   BUSY                 at least one request in flight
// ---------------------------------------------------------------------------
module packet_loader_mc #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int AFLD_W  = 16,
   parameter int TAG_W   = 16,
   parameter int DEPTH   = 4,
   parameter int N_CH    = 3,
   parameter int OPC_LSB = 28,
   parameter int OPC_W   = 4,
   parameter logic [N_CH*OPC_W-1:0] CH_OPCODES = {4'd2, 4'd1, 4'd0}
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [ADDR_W-1:0]         OPADDR,
   input  logic                      RECEIVE_PR_VALID,
   input  logic [AFLD_W+TAG_W-1:0]   RECEIVE_PR_DATA,
   output logic                      RECEIVE_PR_READY,
   output logic                      MEM_SEND_ADDR_VALID,
   output logic [ADDR_W-1:0]         MEM_SEND_ADDR,
   input  logic                      MEM_SEND_READY,
   output logic                      MEM_SEND_DATA_VALID,
   output logic [DATA_W-1:0]         MEM_SEND_DATA,
   input  logic                      MEM_RECEIVE_VALID,
   input  logic [DATA_W-1:0]         MEM_RECEIVE_DATA,
   output logic                      MEM_RECEIVE_READY,
   output logic [N_CH-1:0]           SEND_PC_VALID,
   output logic [TAG_W+DATA_W-1:0]   SEND_PC_DATA,
   input  logic [N_CH-1:0]           SEND_PC_READY,
   output logic [15:0]               DROP_COUNT,
   output logic                      ERR,
   output logic                      BUSY
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PC_W  = TAG_W + DATA_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0]  inflight, inflight_nxt;
   logic              pr_ready, pr_ready_nxt;
   logic              addr_valid, addr_valid_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       drop_cnt;
   logic              err_q;

   // Tag FIFO: tags of accepted requests still waiting for read data.
   logic [TAG_W-1:0]  tag_mem [DEPTH];
   logic [PTR_W-1:0]  tag_wr, tag_rd;
   logic [CNT_W-1:0]  tag_cnt;

   // Result FIFO: {tag, word} pairs waiting to be routed; its head is the
   // output stage.
   logic [PC_W-1:0]   res_mem [DEPTH];
   logic [PTR_W-1:0]  res_wr, res_rd;
   logic [CNT_W-1:0]  res_cnt;

   logic              accept, rsp_ok, pc_fire, drop, pop, hit, head_valid;
   logic [PC_W-1:0]   head;
   logic [OPC_W-1:0]  head_opc;
   logic [N_CH-1:0]   pc_valid;

   assign accept     = RECEIVE_PR_VALID && pr_ready;
   assign rsp_ok     = MEM_RECEIVE_VALID && (tag_cnt != '0);
   assign head       = res_mem[res_rd];
   assign head_valid = (res_cnt != '0);
   assign head_opc   = head[OPC_LSB +: OPC_W];

   // Lowest-numbered matching channel wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      pc_valid = '0;
      hit      = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (!hit && head_opc == CH_OPCODES[i*OPC_W +: OPC_W]) begin
            pc_valid[i] = head_valid;
            hit         = 1'b1;
         end
      end
   end

   assign pc_fire = |(pc_valid & SEND_PC_READY);
   assign drop    = head_valid && !hit;
   assign pop     = pc_fire || drop;

   always_comb begin
      inflight_nxt = inflight;
      if (accept && !pop)      inflight_nxt = inflight + CNT_W'(1);
      else if (!accept && pop) inflight_nxt = inflight - CNT_W'(1);
   end

   assign addr_valid_nxt = accept || (addr_valid && !MEM_SEND_READY);

   // READY is registered, so it cannot see next cycle's MEM_SEND_READY. When
   // the address register will still be occupied, a new request is offered
   // only if memory is accepting this cycle; this keeps one-per-cycle issue
   // and relies on memory not withdrawing READY behind such a grant.
   assign pr_ready_nxt = (inflight_nxt < DEPTH_C) &&
                         (!addr_valid_nxt || MEM_SEND_READY);

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (RST) begin
         inflight   <= '0;
         pr_ready   <= 1'b0;
         addr_valid <= 1'b0;
         addr_q     <= '0;
         tag_wr     <= '0;
         tag_rd     <= '0;
         tag_cnt    <= '0;
         res_wr     <= '0;
         res_rd     <= '0;
         res_cnt    <= '0;
         drop_cnt   <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight   <= inflight_nxt;
         pr_ready   <= pr_ready_nxt;
         addr_valid <= addr_valid_nxt;
         if (accept)
            addr_q <= OPADDR + ADDR_W'(RECEIVE_PR_DATA[AFLD_W-1:0]);

         if (accept) tag_wr <= tag_wr + PTR_W'(1);
         if (rsp_ok) tag_rd <= tag_rd + PTR_W'(1);
         if (accept && !rsp_ok)      tag_cnt <= tag_cnt + CNT_W'(1);
         else if (!accept && rsp_ok) tag_cnt <= tag_cnt - CNT_W'(1);

         if (rsp_ok) res_wr <= res_wr + PTR_W'(1);
         if (pop)    res_rd <= res_rd + PTR_W'(1);
         if (rsp_ok && !pop)      res_cnt <= res_cnt + CNT_W'(1);
         else if (!rsp_ok && pop) res_cnt <= res_cnt - CNT_W'(1);

         // Orphan read data is discarded; only the sticky flag records it.
         if (MEM_RECEIVE_VALID && tag_cnt == '0) err_q <= 1'b1;

         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // NOTE: FIFO storage is not reset; the cleared counts and pointers make
   // stale entries unreachable, so clearing the array would only add logic.
   always_ff @(posedge CLK) begin
      if (accept) tag_mem[tag_wr] <= RECEIVE_PR_DATA[AFLD_W +: TAG_W];
      if (rsp_ok) res_mem[res_wr] <= {tag_mem[tag_rd], MEM_RECEIVE_DATA};
   end

   assign RECEIVE_PR_READY    = pr_ready;
   assign MEM_SEND_ADDR_VALID = addr_valid;
   assign MEM_SEND_ADDR       = addr_q;
   assign MEM_SEND_DATA_VALID = 1'b0;
   assign MEM_SEND_DATA       = '0;
   assign MEM_RECEIVE_READY   = 1'b1;
   assign SEND_PC_VALID       = pc_valid;
   assign SEND_PC_DATA        = head;
   assign DROP_COUNT          = drop_cnt;
   assign ERR                 = err_q;
   assign BUSY                = (inflight != '0);

endmodule

// File: tb/tb_packet_loader_mc.sv
// ---------------------------------------------------------------------------
// tb_packet_loader_mc
// Directed bench for packet_loader_mc (default parameters). A queue-based
// model tracks outstanding tags, expected addresses and routed packets and is
// compared with the outputs every cycle; directed literal checks pin latency,
// stalls, backpressure, drops, errors, reset and address wrap.
// ---------------------------------------------------------------------------
module tb_packet_loader_mc;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] OPADDR;
   logic        RECEIVE_PR_VALID;
   logic [31:0] RECEIVE_PR_DATA;
   logic        RECEIVE_PR_READY;
   logic        MEM_SEND_ADDR_VALID;
   logic [31:0] MEM_SEND_ADDR;
   logic        MEM_SEND_READY;
   logic        MEM_SEND_DATA_VALID;
   logic [31:0] MEM_SEND_DATA;
   logic        MEM_RECEIVE_VALID;
   logic [31:0] MEM_RECEIVE_DATA;
   logic        MEM_RECEIVE_READY;
   logic [2:0]  SEND_PC_VALID;
   logic [47:0] SEND_PC_DATA;
   logic [2:0]  SEND_PC_READY;
   logic [15:0] DROP_COUNT;
   logic        ERR;
   logic        BUSY;

   always #5 CLK = ~CLK;

   packet_loader_mc dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .OPADDR              (OPADDR),
      .RECEIVE_PR_VALID    (RECEIVE_PR_VALID),
      .RECEIVE_PR_DATA     (RECEIVE_PR_DATA),
      .RECEIVE_PR_READY    (RECEIVE_PR_READY),
      .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
      .MEM_SEND_ADDR       (MEM_SEND_ADDR),
      .MEM_SEND_READY      (MEM_SEND_READY),
      .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
      .MEM_SEND_DATA       (MEM_SEND_DATA),
      .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
      .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
      .MEM_RECEIVE_READY   (MEM_RECEIVE_READY),
      .SEND_PC_VALID       (SEND_PC_VALID),
      .SEND_PC_DATA        (SEND_PC_DATA),
      .SEND_PC_READY       (SEND_PC_READY),
      .DROP_COUNT          (DROP_COUNT),
      .ERR                 (ERR),
      .BUSY                (BUSY)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [47:0] m_pkts[$];
   logic [15:0] m_tags[$];
   logic [31:0] m_addrs[$];
   logic [47:0] out_log[$];
   int          m_inflight = 0;
   int          m_drops    = 0;
   bit          m_err      = 1'b0;
   bit          mon_en     = 1'b0;
   logic [2:0]  exp_v;
   logic [2:0]  ch;

   // Opcode field is word[31:28]; channels 0,1,2 take opcodes 0,1,2.
   function automatic logic [2:0] chan_of(input logic [31:0] w);
      case (w[31:28])
         4'd0:    return 3'b001;
         4'd1:    return 3'b010;
         4'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   initial forever begin
      @(negedge CLK);
      if (mon_en) begin
         exp_v = (m_pkts.size() != 0) ? chan_of(m_pkts[0][31:0]) : 3'b000;
         check("pc_valid", SEND_PC_VALID, exp_v);
         if (exp_v != 3'b000) check("pc_data", SEND_PC_DATA, m_pkts[0]);
         check("busy", BUSY, (m_inflight != 0));
         check("drop_count", DROP_COUNT, 64'(m_drops));
         check("err", ERR, m_err);
         check("addr_valid", MEM_SEND_ADDR_VALID, (m_addrs.size() != 0));
         if (m_addrs.size() != 0) check("mem_addr", MEM_SEND_ADDR, m_addrs[0]);
         if (m_inflight >= 4) check("full_ready", RECEIVE_PR_READY, 1'b0);

         if ((SEND_PC_VALID & SEND_PC_READY) != 3'b000) out_log.push_back(SEND_PC_DATA);

         // Advance the model across the coming edge.
         if (RST) begin
            m_pkts.delete(); m_tags.delete(); m_addrs.delete();
            m_inflight = 0; m_drops = 0; m_err = 1'b0;
         end else begin
            if (m_pkts.size() != 0) begin
               ch = chan_of(m_pkts[0][31:0]);
               if (ch == 3'b000) begin
                  void'(m_pkts.pop_front());
                  m_inflight--;
                  if (m_drops < 65535) m_drops++;
               end else if ((ch & SEND_PC_READY) != 3'b000) begin
                  void'(m_pkts.pop_front());
                  m_inflight--;
               end
            end
            if (MEM_SEND_ADDR_VALID && MEM_SEND_READY && m_addrs.size() != 0)
               void'(m_addrs.pop_front());
            if (MEM_RECEIVE_VALID) begin
               if (m_tags.size() != 0) m_pkts.push_back({m_tags.pop_front(), MEM_RECEIVE_DATA});
               else m_err = 1'b1;
            end
            if (RECEIVE_PR_VALID && RECEIVE_PR_READY) begin
               m_tags.push_back(RECEIVE_PR_DATA[31:16]);
               m_addrs.push_back(OPADDR + {16'h0, RECEIVE_PR_DATA[15:0]});
               m_inflight++;
            end
         end
      end
   end

   // ---------------- memory responder ----------------
   int          cyc = 0;
   int          mem_lat = 3;
   logic [31:0] mem_words[$];
   int          due_q[$];
   logic [31:0] rsp_q[$];
   int          hs_cyc[$];
   bit          inject_pending = 1'b0;
   logic [31:0] inject_data = 32'h0;

   initial begin
      MEM_RECEIVE_VALID = 1'b0;
      MEM_RECEIVE_DATA  = 32'h0;
      forever begin
         @(negedge CLK);
         if (MEM_SEND_ADDR_VALID === 1'b1 && MEM_SEND_READY) begin
            hs_cyc.push_back(cyc);
            due_q.push_back(cyc + mem_lat);
            rsp_q.push_back((mem_words.size() != 0) ? mem_words.pop_front() : 32'hF000_0000);
         end
         @(posedge CLK);
         cyc++;
         #1;
         if (due_q.size() != 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA  = rsp_q.pop_front();
         end else if (inject_pending) begin
            inject_pending    = 1'b0;
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA  = inject_data;
         end else begin
            MEM_RECEIVE_VALID = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_req(input logic [15:0] tag, input logic [15:0] a, output int stall);
      stall = 0;
      RECEIVE_PR_DATA  = {tag, a};
      RECEIVE_PR_VALID = 1'b1;
      @(negedge CLK);
      while (!RECEIVE_PR_READY && stall < 100) begin
         @(negedge CLK);
         stall++;
      end
      if (stall >= 100) check("req_timeout", 64'd0, 64'd1);
      tick();
      RECEIVE_PR_VALID = 1'b0;
   endtask

   task automatic wait_pc(input int bound, output int n);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (SEND_PC_VALID == 3'b000 && n < bound);
      if (SEND_PC_VALID == 3'b000) check("pc_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   int st, n;

   initial begin
      RST = 1'b1; OPADDR = 32'h0; RECEIVE_PR_VALID = 1'b0; RECEIVE_PR_DATA = 32'h0;
      MEM_SEND_READY = 1'b1; SEND_PC_READY = 3'b111;
      tick();
      mon_en = 1'b1;
      @(negedge CLK);
      check("rst_pr_ready", RECEIVE_PR_READY, 1'b0);
      check("rst_addr_valid", MEM_SEND_ADDR_VALID, 1'b0);
      check("rst_addr", MEM_SEND_ADDR, 32'h0);
      check("rst_pc_valid", SEND_PC_VALID, 3'b000);
      check("rst_busy", BUSY, 1'b0);
      check("mem_wdata_valid", MEM_SEND_DATA_VALID, 1'b0);
      check("mem_wdata", MEM_SEND_DATA, 32'h0);
      check("mem_rready", MEM_RECEIVE_READY, 1'b1);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check("ready_before_first_edge", RECEIVE_PR_READY, 1'b0);
      @(negedge CLK);
      check("ready_after_reset", RECEIVE_PR_READY, 1'b1);

      // Single request.
      tick();
      OPADDR = 32'h0000_1000; mem_lat = 3;
      mem_words.push_back(32'h1000_0005);
      send_req(16'h00AB, 16'h0010, st);
      @(negedge CLK);
      check("single_addr_valid", MEM_SEND_ADDR_VALID, 1'b1);
      check("single_addr", MEM_SEND_ADDR, 32'h0000_1010);
      wait_pc(20, n);
      check("single_latency", 64'(n), 64'd4);
      check("single_valid", SEND_PC_VALID, 3'b010);
      check("single_data", SEND_PC_DATA, 48'h00AB_1000_0005);
      tick();
      @(negedge CLK);
      check("single_busy_clear", BUSY, 1'b0);

      // Pipelining: four back-to-back, fifth stalls until the first packet leaves.
      tick();
      out_log.delete(); hs_cyc.delete();
      OPADDR = 32'h0000_2000; mem_lat = 5;
      mem_words.push_back(32'h0000_0001); mem_words.push_back(32'h1000_0002);
      mem_words.push_back(32'h2000_0003); mem_words.push_back(32'h0000_0004);
      mem_words.push_back(32'h1000_0005);
      for (int i = 0; i < 4; i++) begin
         send_req(16'h0101 + 16'(i), 16'(i * 4), st);
         check("pipe_no_stall", 64'(st), 64'd0);
      end
      send_req(16'h0105, 16'h0010, st);
      check("full_stall_cycles", 64'(st), 64'd4);
      repeat (14) @(negedge CLK);
      check("pipe_hs_count", 64'(hs_cyc.size()), 64'd5);
      for (int i = 0; i < 3; i++)
         check("pipe_hs_consecutive", 64'(hs_cyc[i+1] - hs_cyc[i]), 64'd1);
      check("pipe_out_count", 64'(out_log.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         check("pipe_tag_order", out_log[i][47:32], 16'h0101 + 16'(i));

      // Backpressure on channel 0; the opcode-1 packet must wait behind it.
      tick();
      SEND_PC_READY = 3'b110; mem_lat = 2;
      mem_words.push_back(32'h0000_00AA); mem_words.push_back(32'h1000_00BB);
      send_req(16'h0201, 16'h0040, st);
      send_req(16'h0202, 16'h0044, st);
      wait_pc(20, n);
      for (int i = 0; i < 10; i++) begin
         if (i != 0) @(negedge CLK);
         check("bp_valid", SEND_PC_VALID, 3'b001);
         check("bp_data", SEND_PC_DATA, 48'h0201_0000_00AA);
      end
      tick();
      SEND_PC_READY = 3'b111;
      @(negedge CLK);
      @(negedge CLK);
      check("bp_next_valid", SEND_PC_VALID, 3'b010);
      check("bp_next_data", SEND_PC_DATA, 48'h0202_1000_00BB);

      // Drop of an unroutable opcode.
      repeat (3) @(negedge CLK);
      tick();
      mem_words.push_back(32'hF000_0000); mem_words.push_back(32'h2000_0077);
      send_req(16'h0301, 16'h0050, st);
      send_req(16'h0302, 16'h0054, st);
      wait_pc(20, n);
      check("drop_next_valid", SEND_PC_VALID, 3'b100);
      check("drop_next_data", SEND_PC_DATA, 48'h0302_2000_0077);
      check("drop_count_one", DROP_COUNT, 16'd1);
      tick();
      @(negedge CLK);
      check("drop_busy_clear", BUSY, 1'b0);

      // Orphan response.
      tick();
      inject_data = 32'h0000_0123; inject_pending = 1'b1;
      repeat (4) @(negedge CLK);
      check("orphan_err", ERR, 1'b1);
      check("orphan_drop_unchanged", DROP_COUNT, 16'd1);
      check("orphan_no_packet", SEND_PC_VALID, 3'b000);

      // Reset with three requests in flight; their late responses set ERR.
      tick();
      mem_lat = 6;
      mem_words.push_back(32'h0000_0001); mem_words.push_back(32'h1000_0002);
      mem_words.push_back(32'h2000_0003);
      send_req(16'h0401, 16'h0060, st);
      send_req(16'h0402, 16'h0064, st);
      send_req(16'h0403, 16'h0068, st);
      RST = 1'b1;
      @(negedge CLK);
      check("pre_reset_busy", BUSY, 1'b1);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check("mid_rst_pr_ready", RECEIVE_PR_READY, 1'b0);
      check("mid_rst_addr_valid", MEM_SEND_ADDR_VALID, 1'b0);
      check("mid_rst_addr", MEM_SEND_ADDR, 32'h0);
      check("mid_rst_pc_valid", SEND_PC_VALID, 3'b000);
      check("mid_rst_drop", DROP_COUNT, 16'd0);
      check("mid_rst_err", ERR, 1'b0);
      check("mid_rst_busy", BUSY, 1'b0);
      @(negedge CLK);
      check("mid_rst_ready_back", RECEIVE_PR_READY, 1'b1);
      repeat (10) @(negedge CLK);
      check("late_rsp_err", ERR, 1'b1);
      check("late_rsp_no_packet", SEND_PC_VALID, 3'b000);
      check("late_rsp_busy", BUSY, 1'b0);

      // Address wrap.
      tick();
      OPADDR = 32'hFFFF_FFF0; mem_lat = 1;
      mem_words.push_back(32'h1000_0009);
      send_req(16'h0501, 16'h0020, st);
      @(negedge CLK);
      check("wrap_addr_valid", MEM_SEND_ADDR_VALID, 1'b1);
      check("wrap_addr", MEM_SEND_ADDR, 32'h0000_0010);
      wait_pc(20, n);
      check("wrap_valid", SEND_PC_VALID, 3'b010);
      check("wrap_data", SEND_PC_DATA, 48'h0501_1000_0009);
      tick();
      @(negedge CLK);
      check("wrap_busy_clear", BUSY, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
